instr_reg_sched: RTL and testbench
==================================

# instr_reg_sched

Write scheduler and occupancy controller for the 32-entry `instr_register`. It arbitrates instruction load requests from `NUM_REQ` requesters onto the register's single write port and drives `load_en`, `write_pointer`, `opcode`, `operand_a` and `operand_b`. It also walks `read_pointer` as a consumer pops entries, so the register behaves as a circular instruction queue with full/empty tracking.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2..4.
- `DEPTH`, fixed 32: entry count, tied to `address_t`; not overridable.

Ports (clock and reset first):
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_valid` in `NUM_REQ`: per-requester load request.
- `req_opcode` in `NUM_REQ` x `opcode_t`: per-requester opcode.
- `req_operand_a` in `NUM_REQ` x `operand_t`: per-requester operand A.
- `req_operand_b` in `NUM_REQ` x `operand_t`: per-requester operand B.
- `req_ready` out `NUM_REQ`: one-hot grant; a transfer occurs when valid and ready are both high at a `clk` rising edge.
- `load_en` out 1: write strobe to the register.
- `write_pointer` out `address_t`: write address.
- `opcode` out `opcode_t`: muxed from the granted requester.
- `operand_a` out `operand_t`: muxed from the granted requester.
- `operand_b` out `operand_t`: muxed from the granted requester.
- `pop` in 1: consumer has taken the entry at `read_pointer`.
- `read_pointer` out `address_t`: oldest valid entry.
- `count` out 6: occupancy, 0..32.
- `full` out 1: high when `count` == 32.
- `empty` out 1: high when `count` == 0.
- `grant_id` out 2: index of the current grantee; 0 when there is no grant.

## Operation
- State: `wr_ptr` (5b), `rd_ptr` (5b), `count` (6b), `last_grant` (2b); all registered.
- Arbitration, combinational:
  - Eligible set is `req_valid & ~full`.
  - Search starts at `last_grant`+1 modulo `NUM_REQ` and takes the first eligible requester.
  - `req_ready` is the one-hot of the winner; all zero if none is eligible or `full` is high.
- Write path:
  - `load_en` = OR of `req_ready & req_valid`.
  - `write_pointer` = `wr_ptr`.
  - Data outputs mux from the winner; they are 0 when there is no grant.
- On a grant edge:
  - `wr_ptr` increments, wrapping 31->0.
  - `last_grant` takes the winner's index.
- Pop:
  - Honoured only when `empty` is low; `rd_ptr` increments with wrap 31->0.
  - A pop while empty is ignored: no pointer or count change.
- Count update:
  - +1 on grant only.
  - -1 on honoured pop only.
  - Unchanged when both occur in the same cycle.
- `full` and `empty` decode the registered `count`. `ready` does not look ahead to a same-cycle pop, so a full queue accepts nothing even while popping.
- `read_pointer` = `rd_ptr`. The consumer samples `instruction_word` from `instr_register` combinationally before asserting `pop`.
- A requester holding `req_valid` must keep its data stable until granted.

## Timing
- Reset (asynchronous, while `reset_n` is low):
  - `wr_ptr`, `rd_ptr`, `count` = 0.
  - `last_grant` = `NUM_REQ`-1, so requester 0 has first priority after reset.
  - `req_ready` = 0, `load_en` = 0, `write_pointer` = 0, `read_pointer` = 0, `count` = 0, `empty` = 1, `full` = 0, `grant_id` = 0, data outputs = 0.
  - All combinational outputs are gated by `reset_n`.
- Reset mid-operation:
  - Queue contents are discarded; `instr_register` clears on the same `reset_n`.
  - Outstanding requests are re-arbitrated from requester 0 after release.
- Write latency: zero. The grant, `load_en` and address share the same cycle, and the register writes at that edge.
- The entry is readable, with `empty` low, in the cycle after the grant edge.
- Throughput: one grant per cycle; one pop per cycle.
- Wrap: entry 31 is followed by entry 0 on both pointers; `count` disambiguates full from empty when `wr_ptr` equals `rd_ptr`.

## Configuration
- `INSTR_SCHED_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins; `last_grant` is not used for arbitration.
  - Undefined (default): round-robin as described in Operation.

## Structure
- `instr_register_pkg` provides `opcode_t`, `operand_t` and `address_t`.
- Add to `instr_register_pkg`: `localparam INSTR_DEPTH = 32` and `localparam MAX_REQ = 4`.
- Sub-module `instr_rr_arb`:
  - Inputs: `req` vector and `last_grant`.
  - Outputs: one-hot `gnt` and `gnt_id`.
  - Houses the `INSTR_SCHED_FIXED_PRIO_EN` selection.

## Test plan
- Reset, then req0 valid alone with ADD, a=5, b=3 -> same cycle: `load_en`=1, `write_pointer`=0, `req_ready`=01. Next cycle: `count`=1, `empty`=0.
- req0 and req1 held valid for 4 cycles -> grants 0,1,0,1; `write_pointer` 0..3; `count`=4. With `INSTR_SCHED_FIXED_PRIO_EN` -> grants 0,0,0,0.
- Fill with 32 grants -> `full`=1, `req_ready`=0 on cycle 33. A pop in the same cycle as a held request -> no grant that cycle, `count`=31, then the grant proceeds to 32 with `wr_ptr` wrapped to 0.
- From empty, assert `pop` -> `rd_ptr` and `count` unchanged. Grant and pop in the same cycle with `count`=5 -> `count` stays 5, both pointers advance.
- Write 34 entries while popping -> `read_pointer` wraps 31->0 and readback order matches write order.
- Assert `reset_n` low while `count`=7 and req1 is valid -> `count`=0, `req_ready`=0 immediately. After release, requester 0 gets first priority.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its write scheduler.
//   opcode_t  : instruction opcode
//   operand_t : signed 32-bit operand
//   address_t : entry index into the 32-entry register
package instr_register_pkg;
  localparam int INSTR_DEPTH = 32;
  localparam int MAX_REQ     = 4;

  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef logic signed [31:0]                 operand_t;
  typedef logic [$clog2(INSTR_DEPTH)-1:0]     address_t;
endpackage

// File: rtl/instr_rr_arb.sv
// Combinational arbiter for the instruction register write port.
//   req        : eligible requesters
//   last_grant : index of the previous winner (round-robin pointer)
//   gnt        : one-hot winner, zero when nothing is requested
//   gnt_id     : index of the winner, zero when nothing is requested
// Build option: INSTR_SCHED_FIXED_PRIO_EN selects fixed priority (lowest
// index wins) instead of round-robin.
module instr_rr_arb
  import instr_register_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_id
);

`ifdef INSTR_SCHED_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  // Descending scan so the lowest requesting index is written last.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = NUM_REQ'(1) << i;
        gnt_id = 2'(i);
      end
    end
  end
`else
  // Search order is last_grant+1, last_grant+2, ... (mod NUM_REQ). Scanning
  // that order backwards lets the nearest candidate overwrite the others.
  always_comb begin
    int idx;
    gnt    = '0;
    gnt_id = '0;
    idx    = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        gnt    = NUM_REQ'(1) << idx;
        gnt_id = 2'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/instr_reg_sched.sv
// Write scheduler and occupancy controller for the 32-entry instr_register.
// Treats the register as a circular queue: requesters are arbitrated onto
// the single write port (zero latency: grant, load_en and address share a
// cycle) and read_pointer walks forward as the consumer pops.
// Ports:
//   clk, reset_n                       : clock, async active-low reset
//   req_valid/req_ready                : per-requester handshake (ready one-hot)
//   req_opcode/req_operand_a/_b        : per-requester instruction fields
//   load_en, write_pointer             : register write strobe and address
//   opcode, operand_a, operand_b       : winner's fields, zero without a grant
//   pop, read_pointer                  : consumer pop and oldest entry address
//   count, full, empty                 : occupancy 0..32 and its decodes
//   grant_id                           : winner index, zero without a grant
// Build option: INSTR_SCHED_FIXED_PRIO_EN (see instr_rr_arb).
module instr_reg_sched
  import instr_register_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  opcode_t  [NUM_REQ-1:0]     req_opcode,
  input  operand_t [NUM_REQ-1:0]     req_operand_a,
  input  operand_t [NUM_REQ-1:0]     req_operand_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       load_en,
  output address_t                   write_pointer,
  output opcode_t                    opcode,
  output operand_t                   operand_a,
  output operand_t                   operand_b,
  input  logic                       pop,
  output address_t                   read_pointer,
  output logic [5:0]                 count,
  output logic                       full,
  output logic                       empty,
  output logic [1:0]                 grant_id
);

  localparam int         DEPTH    = INSTR_DEPTH;
  localparam logic [1:0] LAST_RST = 2'(NUM_REQ - 1);

  address_t            wr_ptr, rd_ptr;
  logic [1:0]          last_grant;
  logic [NUM_REQ-1:0]  elig, gnt;
  logic [1:0]          gnt_id;
  logic                pop_ok;

  assign full  = (count == 6'(DEPTH));
  assign empty = (count == 6'd0);

  // No look-ahead to a same-cycle pop: a full queue accepts nothing.
  // Gating with reset_n keeps every strobe quiet while reset is held.
  assign elig = req_valid & {NUM_REQ{~full & reset_n}};

  instr_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (elig),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  assign req_ready     = gnt;
  assign load_en       = |(req_ready & req_valid);
  assign grant_id      = gnt_id;
  assign write_pointer = wr_ptr;
  assign read_pointer  = rd_ptr;
  assign pop_ok        = pop & ~empty & reset_n;

  always_comb begin
    opcode    = ZERO;
    operand_a = '0;
    operand_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        opcode    = req_opcode[i];
        operand_a = req_operand_a[i];
        operand_b = req_operand_b[i];
      end
    end
  end

  // Pointers wrap naturally at 5 bits; count tells full from empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= LAST_RST;
    end else begin
      if (load_en) begin
        wr_ptr     <= wr_ptr + 1'b1;
        last_grant <= gnt_id;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({load_en, pop_ok})
        2'b10:   count <= count + 6'd1;
        2'b01:   count <= count - 6'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_reg_sched.sv
// Randomized scoreboard bench for instr_reg_sched. The reference model keeps
// the queue as an SV queue of entries plus pointer counters; expected grants
// and pops are queued at issue and consumed by an independent monitor.
module tb_instr_reg_sched;
  import instr_register_pkg::*;

  localparam int NR = 2;

  typedef struct packed {
    opcode_t  opc;
    operand_t a;
    operand_t b;
  } entry_t;

  typedef struct {
    int     id;
    int     wp;
    entry_t e;
  } gnt_t;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NR-1:0]        req_valid = '0;
  opcode_t  [NR-1:0]    req_opcode;
  operand_t [NR-1:0]    req_operand_a;
  operand_t [NR-1:0]    req_operand_b;
  logic [NR-1:0]        req_ready;
  logic                 load_en;
  address_t             write_pointer;
  opcode_t              opcode;
  operand_t             operand_a;
  operand_t             operand_b;
  logic                 pop = 1'b0;
  address_t             read_pointer;
  logic [5:0]           count;
  logic                 full;
  logic                 empty;
  logic [1:0]           grant_id;

  always #5 clk = ~clk;

  instr_reg_sched #(.NUM_REQ(NR)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_opcode    (req_opcode),
    .req_operand_a (req_operand_a),
    .req_operand_b (req_operand_b),
    .req_ready     (req_ready),
    .load_en       (load_en),
    .write_pointer (write_pointer),
    .opcode        (opcode),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .pop           (pop),
    .read_pointer  (read_pointer),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .grant_id      (grant_id)
  );

  // Stand-in for instr_register storage, written by the DUT's write port.
  entry_t mem [32];
  always @(posedge clk) if (load_en) mem[write_pointer] <= {opcode, operand_a, operand_b};

  // Reference model state
  entry_t        m_q[$];
  int            m_wr = 0, m_rd = 0, m_last = NR - 1;
  gnt_t          exp_q[$];
  entry_t        rd_q[$];
  logic [NR-1:0] hold = '0;
  bit            rand_data = 1'b1;
  int            n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, predict the outcome, advance the model.
  task automatic step(input logic [NR-1:0] v, input bit p);
    logic [NR-1:0] ev;
    int            win, idx;
    bit            pop_ok;
    entry_t        we;
    ev = v | hold;
    for (int i = 0; i < NR; i++) begin
      if (!hold[i] && rand_data) begin
        req_opcode[i]    = opcode_t'($urandom_range(0, 7));
        req_operand_a[i] = $urandom;
        req_operand_b[i] = $urandom;
      end
    end
    req_valid = ev;
    pop       = p;
    win = -1;
    if (m_q.size() < 32) begin
      for (int k = 1; k <= NR; k++) begin
`ifdef INSTR_SCHED_FIXED_PRIO_EN
        idx = k - 1;
`else
        idx = (m_last + k) % NR;
`endif
        if (ev[idx] && win < 0) win = idx;
      end
    end
    we = '0;
    if (win >= 0) begin
      we = {req_opcode[win], req_operand_a[win], req_operand_b[win]};
      exp_q.push_back('{win, m_wr, we});
    end
    pop_ok = p && (m_q.size() > 0);
    if (pop_ok) rd_q.push_back(m_q[0]);
    @(posedge clk);
    #1;
    if (pop_ok) begin
      m_q.delete(0);
      m_rd = (m_rd + 1) % 32;
    end
    if (win >= 0) begin
      m_q.push_back(we);
      m_wr   = (m_wr + 1) % 32;
      m_last = win;
    end
    hold = ev;
    if (win >= 0) hold[win] = 1'b0;
  endtask

  // Monitor: compares DUT outputs mid-cycle against queued expectations.
  always @(negedge clk) begin
    gnt_t   g;
    entry_t e;
    if (reset_n) begin
      chk("count", count, m_q.size());
      chk("full", full, m_q.size() == 32);
      chk("empty", empty, m_q.size() == 0);
      chk("read_pointer", read_pointer, m_rd);
      chk("write_pointer", write_pointer, m_wr);
      if (load_en) begin
        if (exp_q.size() == 0) chk("unexpected_load_en", load_en, 0);
        else begin
          g = exp_q.pop_front();
          chk("grant_id", grant_id, g.id);
          chk("req_ready", req_ready, 1 << g.id);
          chk("grant_addr", write_pointer, g.wp);
          chk("grant_data", {opcode, operand_a, operand_b}, g.e);
        end
      end else if (exp_q.size() > 0) begin
        g = exp_q.pop_front();
        chk("missing_load_en", load_en, 1);
      end else begin
        chk("idle_ready", req_ready, 0);
        chk("idle_grant_id", grant_id, 0);
      end
      if (pop && !empty) begin
        if (rd_q.size() == 0) chk("pop_honoured", empty, 1);
        else begin
          e = rd_q.pop_front();
          chk("readback", mem[read_pointer], e);
        end
      end else if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        chk("pop_missed", empty, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      req_opcode[i] = ZERO; req_operand_a[i] = '0; req_operand_b[i] = '0;
    end
    // Reset with requests and pop asserted: every strobe must stay low.
    req_valid = '1;
    pop = 1'b1;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_load_en", load_en, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_wp", write_pointer, 0);
    chk("rst_rp", read_pointer, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_data", {opcode, operand_a, operand_b}, 0);
    req_valid = '0;
    pop = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Single ADD 5,3 from requester 0
    rand_data = 1'b0;
    req_opcode[0] = ADD; req_operand_a[0] = 5; req_operand_b[0] = 3;
    step(2'b01, 1'b0);
    rand_data = 1'b1;
    chk("first_count", count, 1);
    chk("first_empty", empty, 0);

    // Both requesters held: alternating grants (fixed build: always 0)
    repeat (4) step(2'b11, 1'b0);

    // Fill to full, then pop while a request is held
    for (int i = 0; i < 40 && m_q.size() < 32; i++) step(2'b01, 1'b0);
    chk("fill_full", full, 1);
    step(2'b01, 1'b0);
    step(2'b01, 1'b1);
    chk("pop_while_full_count", count, 31);
    step(2'b01, 1'b0);
    chk("refill_count", count, 32);
    chk("refill_wp_wrap", write_pointer, m_wr);

    // Drain, then pop on empty
    for (int i = 0; i < 40 && m_q.size() > 0; i++) step('0, 1'b1);
    step('0, 1'b1);
    step('0, 1'b1);

    // Random traffic: filling then draining mix
    repeat (250) step(NR'($urandom), $urandom_range(0, 9) < 3);
    repeat (250) step(NR'($urandom), $urandom_range(0, 9) < 9);

    // Reset mid-operation with requester 1 valid
    for (int i = 0; i < 40 && hold != '0; i++) step('0, 1'b0);
    repeat (7) step(2'b10, 1'b0);
    req_valid = 2'b10;
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", req_ready, 0);
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    m_q.delete();
    m_wr = 0; m_rd = 0; m_last = NR - 1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    hold = 2'b11;
    step('0, 1'b0);
    chk("post_rst_first_writer", mem[0].opc, req_opcode[0]);
    repeat (40) step(NR'($urandom), $urandom_range(0, 1) == 1);

    for (int i = 0; i < 40 && hold != '0; i++) step('0, 1'b1);
    for (int i = 0; i < 40 && m_q.size() > 0; i++) step('0, 1'b1);
    step('0, 1'b0);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
